// File: rtl/sw_alloc_credit.sv
// Oldest-first single-output switch allocator with internal downstream credit counters.
// Optional SW_ALLOC_RR_TIEBREAK_EN: round-robin tiebreak among equal-timestamp requesters.
module sw_alloc_credit #(
  parameter int NUM_PORTS    = 5,
  parameter int NUM_VC       = 4,
  parameter int TIME_WIDTH   = 8,
  parameter int CREDIT_DEPTH = 4,
  localparam int PC_W  = $clog2(NUM_PORTS + 1),
  localparam int VC_W  = $clog2(NUM_VC),
  localparam int CNT_W = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          req_in,
  input  logic [NUM_PORTS*TIME_WIDTH-1:0] time_in,
  input  logic [NUM_PORTS*VC_W-1:0]     vc_in,
  input  logic                          credit_ret_valid,
  input  logic [VC_W-1:0]               credit_ret_vc,
  output logic                          grant_valid,
  output logic [PC_W-1:0]               grant_pc,
  output logic [NUM_PORTS-1:0]          grant_onehot,
  output logic [VC_W-1:0]               grant_vc,
  output logic [NUM_VC*CNT_W-1:0]       credit_cnt
);

  logic [CNT_W-1:0]      cnt_q [NUM_VC];
  logic                  found;
  logic [TIME_WIDTH-1:0] best_t;
  logic [VC_W-1:0]       win_req_vc;
  logic                  req_vc_ok;
  logic                  any_credit;
  logic [VC_W-1:0]       alt_vc;
  logic                  alt_found;
  logic [NUM_VC-1:0]     cnt_dec;
  logic [NUM_VC-1:0]     cnt_inc;
  int                    p_idx;

  logic                  win_vld_p0;
  logic [PC_W-1:0]       win_pc_p0;
  logic [VC_W-1:0]       win_vc_p0;

  // A simultaneous grant and return cancel; returns saturate at full depth.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                 input logic dec, input logic inc);
    if (dec && !inc)
      return cnt - CNT_W'(1);
    else if (inc && !dec && cnt != CNT_W'(CREDIT_DEPTH))
      return cnt + CNT_W'(1);
    else
      return cnt;
  endfunction

`ifdef SW_ALLOC_RR_TIEBREAK_EN
  logic [PC_W-1:0] rr_ptr;

  function automatic int wrap_idx(input int base, input int k);
    int s;
    s = base + k;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return s;
  endfunction
`endif

  // Stage p0: oldest-first arbitration and VC selection
  always_comb begin
    found      = 1'b0;
    best_t     = '0;
    win_pc_p0  = PC_W'(NUM_PORTS);
    win_req_vc = '0;
    p_idx      = 0;
    // Scan in priority order; strict compare keeps the first of any tied group.
    for (int k = 0; k < NUM_PORTS; k++) begin
`ifdef SW_ALLOC_RR_TIEBREAK_EN
      p_idx = wrap_idx(int'(rr_ptr), k);
`else
      p_idx = k;
`endif
      if (req_in[p_idx] && (!found || time_in[p_idx*TIME_WIDTH +: TIME_WIDTH] < best_t)) begin
        found      = 1'b1;
        best_t     = time_in[p_idx*TIME_WIDTH +: TIME_WIDTH];
        win_pc_p0  = PC_W'(p_idx);
        win_req_vc = vc_in[p_idx*VC_W +: VC_W];
      end
    end

    req_vc_ok  = 1'b0;
    any_credit = 1'b0;
    alt_found  = 1'b0;
    alt_vc     = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (cnt_q[v] != '0) begin
        any_credit = 1'b1;
        if (!alt_found) begin
          alt_found = 1'b1;
          alt_vc    = VC_W'(v);
        end
        if (int'(win_req_vc) == v) req_vc_ok = 1'b1;
      end
    end
    win_vc_p0  = req_vc_ok ? win_req_vc : alt_vc;
    win_vld_p0 = found && any_credit;

    cnt_dec = '0;
    cnt_inc = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      cnt_dec[v] = win_vld_p0 && (int'(win_vc_p0) == v);
      cnt_inc[v] = credit_ret_valid && (int'(credit_ret_vc) == v);
    end
  end

  // Stage p1: registered grant outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_valid  <= 1'b0;
      grant_pc     <= PC_W'(NUM_PORTS);
      grant_onehot <= '0;
      grant_vc     <= '0;
    end else begin
      grant_valid  <= win_vld_p0;
      grant_pc     <= win_vld_p0 ? win_pc_p0 : PC_W'(NUM_PORTS);
      grant_onehot <= win_vld_p0 ? (NUM_PORTS'(1) << win_pc_p0) : '0;
      grant_vc     <= win_vld_p0 ? win_vc_p0 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) cnt_q[v] <= CNT_W'(CREDIT_DEPTH);
    end else begin
      for (int v = 0; v < NUM_VC; v++) cnt_q[v] <= cnt_next(cnt_q[v], cnt_dec[v], cnt_inc[v]);
    end
  end

`ifdef SW_ALLOC_RR_TIEBREAK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (win_vld_p0)
      rr_ptr <= (win_pc_p0 == PC_W'(NUM_PORTS - 1)) ? '0 : win_pc_p0 + PC_W'(1);
  end
`endif

  for (genvar gv = 0; gv < NUM_VC; gv++) begin : g_cnt_out
    assign credit_cnt[gv*CNT_W +: CNT_W] = cnt_q[gv];
  end

endmodule

// File: tb/tb_sw_alloc_credit.sv
// Bench for sw_alloc_credit: directed scenarios plus random traffic against a spec-level model.
module tb_sw_alloc_credit;
  localparam int NP    = 5;
  localparam int NV    = 4;
  localparam int TW    = 8;
  localparam int DEPTH = 4;
  localparam int PC_W  = $clog2(NP + 1);
  localparam int VC_W  = $clog2(NV);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                 clk;
  logic                 rst_n;
  logic [NP-1:0]        req_in;
  logic [NP*TW-1:0]     time_in;
  logic [NP*VC_W-1:0]   vc_in;
  logic                 credit_ret_valid;
  logic [VC_W-1:0]      credit_ret_vc;
  logic                 grant_valid;
  logic [PC_W-1:0]      grant_pc;
  logic [NP-1:0]        grant_onehot;
  logic [VC_W-1:0]      grant_vc;
  logic [NV*CNT_W-1:0]  credit_cnt;

  sw_alloc_credit #(.NUM_PORTS(NP), .NUM_VC(NV), .TIME_WIDTH(TW), .CREDIT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .time_in(time_in), .vc_in(vc_in),
    .credit_ret_valid(credit_ret_valid), .credit_ret_vc(credit_ret_vc),
    .grant_valid(grant_valid), .grant_pc(grant_pc), .grant_onehot(grant_onehot),
    .grant_vc(grant_vc), .credit_cnt(credit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int mcnt [NV];
  int mptr;
  int ti [NP];
  int vi [NP];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int v);
    return 32'(credit_cnt[v*CNT_W +: CNT_W]);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) mcnt[v] = DEPTH;
    mptr = 0;
  endtask

  task automatic set_all(input int t, input int v);
    for (int p = 0; p < NP; p++) begin
      ti[p] = t;
      vi[p] = v;
    end
  endtask

  // One cycle: drive, clock, compare grant and counters with the model, advance the model.
  task automatic step(input logic [NP-1:0] r, input bit rv, input int rvc);
    int  min_t, win, best_d, d, ev, tot;
    bit  any, g;
    any = 0; min_t = 0; win = -1; best_d = NP; ev = 0; tot = 0;
    for (int p = 0; p < NP; p++)
      if (r[p] && (!any || ti[p] < min_t)) begin
        any = 1;
        min_t = ti[p];
      end
    for (int v = 0; v < NV; v++) tot += mcnt[v];
    g = any && (tot > 0);
    if (g) begin
      for (int p = 0; p < NP; p++)
        if (r[p] && ti[p] == min_t) begin
`ifdef SW_ALLOC_RR_TIEBREAK_EN
          d = (p - mptr + NP) % NP;
`else
          d = p;
`endif
          if (d < best_d) begin
            best_d = d;
            win = p;
          end
        end
      if (vi[win] < NV && mcnt[vi[win]] > 0) ev = vi[win];
      else begin
        ev = -1;
        for (int v = 0; v < NV; v++) if (ev < 0 && mcnt[v] > 0) ev = v;
      end
    end

    req_in = r;
    for (int p = 0; p < NP; p++) begin
      time_in[p*TW +: TW]   = TW'(ti[p]);
      vc_in[p*VC_W +: VC_W] = VC_W'(vi[p]);
    end
    credit_ret_valid = rv;
    credit_ret_vc    = VC_W'(rvc);
    @(posedge clk);
    #1;

    chk("grant_valid", 32'(grant_valid), 32'(g));
    chk("grant_pc", 32'(grant_pc), g ? win : NP);
    chk("grant_onehot", 32'(grant_onehot), g ? (32'd1 << win) : 32'd0);
    chk("grant_vc", 32'(grant_vc), g ? ev : 0);

    for (int v = 0; v < NV; v++) begin
      bit dd, ii;
      dd = g && (ev == v);
      ii = rv && (rvc == v);
      if (dd && !ii) mcnt[v]--;
      else if (ii && !dd && mcnt[v] < DEPTH) mcnt[v]++;
      chk($sformatf("credit_cnt[%0d]", v), cnt_of(v), mcnt[v]);
    end
    if (g) mptr = (win + 1) % NP;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(grant_valid), 0);
    chk({tag, "_pc"}, 32'(grant_pc), NP);
    chk({tag, "_onehot"}, 32'(grant_onehot), 0);
    chk({tag, "_vc"}, 32'(grant_vc), 0);
  endtask

  int exp_seq [4];

  initial begin
    rst_n = 1'b0;
    req_in = '0; time_in = '0; vc_in = '0;
    credit_ret_valid = 1'b0; credit_ret_vc = '0;
    set_all(0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    for (int v = 0; v < NV; v++) chk($sformatf("reset_cnt[%0d]", v), cnt_of(v), DEPTH);
    rst_n = 1'b1;

    // Oldest requester wins, lowest index among the tied pair
    set_all(0, 1);
    ti[1] = 9; ti[2] = 3; ti[4] = 3;
    step(5'b10110, 0, 0);
    chk("s1_pc", 32'(grant_pc), 2);
    chk("s1_onehot", 32'(grant_onehot), 32'b00100);
    chk("s1_vc", 32'(grant_vc), 1);
    chk("s1_cnt1", cnt_of(1), 3);
    step(5'b00000, 0, 0);
    chk("idle_pc", 32'(grant_pc), NP);

    // Drain vc2, then the next request is reallocated to vc0
    set_all(0, 2);
    repeat (4) step(5'b00001, 0, 0);
    chk("drain_cnt2", cnt_of(2), 0);
    step(5'b00001, 0, 0);
    chk("realloc_vc", 32'(grant_vc), 0);
    chk("realloc_cnt0", cnt_of(0), 3);

    // Exhaust every credit, then a return is only usable the following cycle
    repeat (12) step(5'b00001, 0, 0);
    chk("empty_valid", 32'(grant_valid), 0);
    chk("empty_pc", 32'(grant_pc), NP);
    step(5'b00001, 1, 3);
    chk("nobypass_valid", 32'(grant_valid), 0);
    step(5'b00001, 0, 0);
    chk("ret_vc", 32'(grant_vc), 3);

    // Grant and return on the same VC cancel; return at full saturates
    set_all(0, 1);
    step(5'b00000, 1, 1);
    step(5'b00000, 1, 1);
    chk("pre_cnt1", cnt_of(1), 2);
    step(5'b00001, 1, 1);
    chk("cancel_vc", 32'(grant_vc), 1);
    chk("cancel_cnt1", cnt_of(1), 2);
    repeat (5) step(5'b00000, 1, 0);
    chk("sat_cnt0", cnt_of(0), DEPTH);

    // Asynchronous reset mid-stream with a grant pending
    step(5'b00001, 0, 0);
    chk("pre_reset_valid", 32'(grant_valid), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int v = 0; v < NV; v++) chk($sformatf("midreset_cnt[%0d]", v), cnt_of(v), DEPTH);

    // Equal timestamps on ports 0, 1, 3
`ifdef SW_ALLOC_RR_TIEBREAK_EN
    exp_seq = '{0, 1, 3, 0};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    set_all(5, 0);
    for (int i = 0; i < 4; i++) begin
      step(5'b01011, 0, 0);
      chk($sformatf("tie_%0d", i), 32'(grant_pc), exp_seq[i]);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [NP-1:0] r;
      for (int p = 0; p < NP; p++) begin
        ti[p] = $urandom_range(0, 3);
        vi[p] = $urandom_range(0, NV - 1);
      end
      r = NP'($urandom);
      step(r, bit'($urandom_range(0, 1)), $urandom_range(0, NV - 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sw_alloc_credit.md
# sw_alloc_credit

Parametrised, registered successor of the 5-port oldest-first switch arbiter. It selects one winning input port per cycle by smallest timestamp among requesters and reassigns the winner's VC when the requested downstream VC has no credit. Downstream per-VC credit counters are kept internally, replacing externally supplied credit levels. It sits between the input-port VC buffers and the crossbar select of one output port.

## Interface
- NUM_PORTS, 5, number of requesting input ports (≥2)
- NUM_VC, 4, downstream VCs (≥2)
- TIME_WIDTH, 8, timestamp width; smaller value = older
- CREDIT_DEPTH, 4, downstream buffer slots per VC (≥1)
- PC_W, derived, clog2(NUM_PORTS+1); VC_W, derived, clog2(NUM_VC); CNT_W, derived, clog2(CREDIT_DEPTH+1)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_in  in  NUM_PORTS  per-port request
- time_in  in  NUM_PORTS*TIME_WIDTH  per-port timestamp, port p at [p*TIME_WIDTH +: TIME_WIDTH]
- vc_in  in  NUM_PORTS*VC_W  per-port requested VC
- credit_ret_valid  in  1  one credit returned by downstream this cycle
- credit_ret_vc  in  VC_W  VC of returned credit
- grant_valid  out  1  registered; a grant was issued
- grant_pc  out  PC_W  registered winning port; NUM_PORTS (null) when grant_valid=0
- grant_onehot  out  NUM_PORTS  registered one-hot of grant_pc; zero when no grant
- grant_vc  out  VC_W  registered VC assigned to winner; 0 when no grant
- credit_cnt  out  NUM_VC*CNT_W  current credit counters, observation only

## Operation
- Arbitration (combinational, cycle t): among ports with req_in=1, winner = minimum time_in. Equal timestamps: lowest port index wins (default build).
- VC selection for winner: keep vc_in[winner] if its counter >0; otherwise lowest-index VC with counter >0.
- No grant when there are no requests, or when every counter is 0. In either case nothing is consumed.
- Counter update at the edge ending cycle t, per VC v: dec = grant issued with VC v; inc = credit_ret_valid and credit_ret_vc==v.
  - dec and inc both set: counter unchanged.
  - Only one set: counter −1 or +1.
  - Increment saturates at CREDIT_DEPTH.
  - A returned credit in cycle t is usable for arbitration from cycle t+1. There is no same-cycle bypass.
- vc_in values ≥ NUM_VC are treated as "no credit" and force reallocation.

## Timing
- Latency: request in cycle t → grant_* valid in cycle t+1, for exactly one cycle. Requesters re-request every cycle they still hold a flit; there is no hold handshake.
- Back-to-back grants are allowed every cycle.
- Reset (asynchronous assert, synchronous-to-clk deassert expected):
  - grant_valid=0, grant_pc=NUM_PORTS, grant_onehot=0, grant_vc=0.
  - All counters = CREDIT_DEPTH. RR pointer = 0.
- Reset mid-operation discards any pending grant and in-flight credit returns; counters restore to full.

## Configuration
- SW_ALLOC_RR_TIEBREAK_EN defined:
  - Timestamp ties are broken round-robin. A registered pointer names the highest-priority port. Among tied oldest requesters, the first at or after the pointer (wrapping) wins.
  - On every issued grant the pointer moves to (grant_pc+1) mod NUM_PORTS. Without a grant the pointer holds.
- Undefined: fixed lowest-index tiebreak, and no pointer register exists.

## Test plan
- Defaults; after reset, req_in=5'b10110 with times {p1=9, p2=3, p4=3}, all vc_in=1 → cycle+1: grant_pc=2, grant_onehot=5'b00100, grant_vc=1; vc1 counter 4→3.
- Drain vc2: ports request vc2 for four consecutive grants with no returns → vc2 counter reaches 0. Fifth request for vc2 → grant_vc=0 (reallocated) and vc0 counter decrements.
- Exhaust all 16 credits; keep requesting → grant_valid=0, grant_pc=5. Pulse credit_ret_valid with vc=3 → grant on the following cycle with grant_vc=3.
- Grant to vc1 and credit_ret_vc=1 in the same cycle, starting at counter 2 → counter stays 2. A return at counter 4 with no grant → stays 4.
- With SW_ALLOC_RR_TIEBREAK_EN: ports 0, 1, 3 request every cycle with equal time=5 → grants rotate 0, 1, 3, 0. Without the macro → port 0 every cycle.
- Assert rst_n=0 mid-stream with counters partially used → outputs go to reset values immediately and counters read 4 after release; NUM_PORTS=8, NUM_VC=2 build passes the first scenario adapted.
